// File: rtl/fifo_access_sched_pkg.sv
// fifo_sched_pkg: shared op encoding and FIFO geometry for the access scheduler
package fifo_sched_pkg;
  typedef enum logic {OP_WR, OP_RD} op_t;
  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_DW = 8;
endpackage

// File: rtl/fifo_access_sched_if.sv
// fifo_access_sched_if: requester, consumer and FIFO-side signals of the access scheduler
interface fifo_access_sched_if
  import fifo_sched_pkg::*;
#(
  parameter int NUM_WR = 4,
  parameter int DW     = FIFO_DW,
  parameter int DEPTH  = FIFO_DEPTH
);
  localparam int OW = $clog2(DEPTH) + 1;
  logic [NUM_WR-1:0]    wr_req;
  logic [NUM_WR*DW-1:0] wr_data;
  logic [NUM_WR-1:0]    wr_ack;
  logic                 rd_req;
  logic [DW-1:0]        rd_data;
  logic                 rd_valid;
  logic                 fifo_wr_en;
  logic                 fifo_rd_en;
  logic [DW-1:0]        fifo_din;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DW-1:0]        fifo_dout;
  logic [OW-1:0]        occupancy;
  logic                 proto_err;
  modport master (
    input  wr_req, wr_data, rd_req, fifo_full, fifo_empty, fifo_dout,
    output wr_ack, rd_data, rd_valid, fifo_wr_en, fifo_rd_en, fifo_din, occupancy, proto_err
  );
  modport slave (
    output wr_req, wr_data, rd_req, fifo_full, fifo_empty, fifo_dout,
    input  wr_ack, rd_data, rd_valid, fifo_wr_en, fifo_rd_en, fifo_din, occupancy, proto_err
  );
endinterface

// File: rtl/fifo_access_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter  int NUM_WR = 4,
  localparam int PW     = NUM_WR > 1 ? $clog2(NUM_WR) : 1
) (
  input  logic [NUM_WR-1:0] i_req,
  input  logic [PW-1:0]     i_ptr,
  output logic [NUM_WR-1:0] o_gnt,
  output logic [PW-1:0]     o_gnt_idx,
  output logic              o_any
);
  always_comb begin
    o_gnt_idx = '0;
    // scan farthest offset first so the nearest request after ptr wins
    for (int i = NUM_WR - 1; i >= 0; i--)
      if (i_req[PW'((int'(i_ptr) + i) % NUM_WR)]) o_gnt_idx = PW'((int'(i_ptr) + i) % NUM_WR);
    o_any = |i_req;
    o_gnt = o_any ? NUM_WR'(1) << o_gnt_idx : '0;
  end
endmodule

// File: rtl/fifo_access_sched.sv
// fifo_access_sched: one FIFO op per cycle, round-robin writers vs. a reader, alternating on contention
module fifo_access_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_WR = 4,
  parameter int DW     = FIFO_DW,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input logic clk,
  input logic reset,
  fifo_access_sched_if.master bus
);
  localparam int PW = NUM_WR > 1 ? $clog2(NUM_WR) : 1;
  localparam int OW = $clog2(DEPTH) + 1;
  logic [PW-1:0]     r_rr_ptr;
  op_t               r_last_op;
  logic              r_rd_valid;
  logic [OW-1:0]     r_occ;
  logic              r_proto_err;
  logic [NUM_WR-1:0] w_gnt;
  logic [PW-1:0]     w_gnt_idx;
  logic              w_any, w_wr_cand, w_rd_cand, w_do_wr, w_do_rd;
  rr_arbiter #(.NUM_WR(NUM_WR)) u_arb (
    .i_req    (bus.wr_req),
    .i_ptr    (r_rr_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_idx(w_gnt_idx),
    .o_any    (w_any)
  );
  always_comb begin
    w_wr_cand = w_any && !bus.fifo_full;
    w_rd_cand = bus.rd_req && !bus.fifo_empty;
    w_do_wr   = !reset && w_wr_cand && (!w_rd_cand || r_last_op == OP_RD);
    w_do_rd   = !reset && w_rd_cand && !w_do_wr;
  end
  assign bus.fifo_wr_en = w_do_wr;
  assign bus.fifo_rd_en = w_do_rd;
  assign bus.fifo_din   = w_do_wr ? bus.wr_data[int'(w_gnt_idx)*DW +: DW] : '0;
  assign bus.wr_ack     = w_do_wr ? w_gnt : '0;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = r_rd_valid ? bus.fifo_dout : '0;
  assign bus.occupancy  = r_occ;
  assign bus.proto_err  = r_proto_err;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_last_op   <= OP_RD;
      r_rd_valid  <= 1'b0;
      r_occ       <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_do_wr) r_rr_ptr <= (w_gnt_idx == PW'(NUM_WR - 1)) ? '0 : w_gnt_idx + PW'(1);
      if (w_do_wr) r_last_op <= OP_WR;
      else if (w_do_rd) r_last_op <= OP_RD;
      r_rd_valid <= w_do_rd;
      r_occ <= w_do_wr ? r_occ + OW'(1) : w_do_rd ? r_occ - OW'(1) : r_occ;
      // shadow count must agree with the FIFO's own flags at every edge
      r_proto_err <= r_proto_err | ((r_occ == '0) != bus.fifo_empty)
                                 | ((r_occ == OW'(DEPTH)) != bus.fifo_full);
    end
  end
endmodule
